alu_cond_writeback: RTL and testbench
=====================================

// Module: alu_cond_writeback
// PURPOSE
//   Execute-to-writeback stage directly downstream of the ALU. Holds the architectural NZCV flags.
//   Evaluates the ARMv4 condition field of each instruction against those flags.
//   Gates the register-write, memory-write and branch enables on the condition result.
//   Updates NZCV from the ALU flag outputs when the S bit is set and the condition passes.
//   Results go through a 2-entry valid/ready buffer into the memory/writeback side.
// PARAMETERS
//   M   32  ALU datapath width (matches the ALU's M)
//   RA  4   destination register address width
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   in_valid     in   1   ALU-side instruction valid
//   in_ready     out  1   stage can accept (buffer not full)
//   in_result    in   M   ALU resultado
//   in_n,in_z,in_v,in_c in 1 each  ALU flags N,Z,V,C for this instruction
//   in_cond      in   4   ARM condition field [31:28]
//   in_setflags  in   1   S bit: update NZCV if condition passes
//   in_rd        in   RA  destination register
//   in_regwrite  in   1   register write requested
//   in_memwrite  in   1   memory write requested
//   in_branch    in   1   branch requested
//   out_valid    out  1   head entry valid
//   out_ready    in   1   downstream accepts head entry
//   out_result   out  M   registered result
//   out_rd       out  RA  registered destination
//   out_regwrite,out_memwrite,out_branch out 1 each  enables, already condition-gated
//   out_condpass out  1   condition outcome of head entry
//   flags_nzcv   out  4   architectural flags {N,Z,C,V}
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): flags_nzcv=0, buffer count=0, out_valid=0, all out_* data=0, in_ready=0 during reset.
//   Reset mid-operation: buffered entries are discarded.
//   Transfers: accept = in_valid&in_ready; pop = out_valid&out_ready; in_ready = (count<2), registered from count.
//   Condition evaluation: at the accept edge, combinationally from flags_nzcv as held before that edge.
//     EQ 0000: Z        NE 0001: !Z
//     CS 0010: C        CC 0011: !C
//     MI 0100: N        PL 0101: !N
//     VS 0110: V        VC 0111: !V
//     HI 1000: C&!Z     LS 1001: !C|Z
//     GE 1010: N==V     LT 1011: N!=V
//     GT 1100: !Z&(N==V)  LE 1101: Z|(N!=V)
//     AL 1110: 1        1111 (NV): always fails
//   Failed condition: the entry is still enqueued with result and rd. regwrite, memwrite and branch are forced 0.
//     out_condpass=0 and the flags are not touched.
//   Flag update: on accept, if pass & in_setflags, flags_nzcv <= {in_n,in_z,in_c,in_v}. It takes effect at that edge.
//   Ordering: the next accepted instruction (next cycle) sees the updated flags, so back-to-back dependency needs no stall.
//   Latency: accepted on edge k, visible on out_* after edge k when the buffer is empty (1 cycle).
//   Buffer: FIFO order, count 0..2.
//     count=2: in_ready=0, in_valid is ignored, flags are not updated.
//     Push and pop in the same cycle at count=1: count stays 1 and the head advances.
//     count=0: pop is impossible (out_valid=0).
//   out_* data are held stable while out_valid=1 and out_ready=0.
//   Width: result and rd are passed unchanged; no arithmetic in this stage.
// TESTING
//   Flags 0000, accept cond=1110, S=1, in_z=1, regwrite=1, result=0 -> next cycle out_regwrite=1, flags_nzcv=0100.
//   Then accept cond=0000 (EQ) back-to-back -> out_condpass=1. Accept cond=0001 (NE) -> condpass=0, enables 0.
//   Flags 0100, accept cond=0001, S=1, in_n=1, memwrite=1 -> out_memwrite=0, flags stay 0100.
//   out_ready=0, push 3 valid entries -> in_ready=0 after 2 and the third is held. out_ready=1 -> FIFO order, count drains.
//   count=1, in_valid=1 & out_ready=1 for 5 cycles -> count stays 1, in_ready=1, one output per cycle.
//   Reset mid-operation: 2 entries buffered, flags 1111, assert rst_n=0 for one edge -> out_valid=0, flags 0000, count=0.
//   Sweep all 16 cond codes x 16 NZCV values -> out_condpass matches the table; cond=1111 always 0.

Source files
------------

// File: rtl/alu_cond_writeback.sv
// Execute-to-writeback stage: evaluates the ARM condition field against the held NZCV flags,
// gates the write/branch enables, updates the flags on S, and buffers results in a 2-entry FIFO.
module alu_cond_writeback #(
    parameter int M  = 32,
    parameter int RA = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_result,
    input  logic          in_n,
    input  logic          in_z,
    input  logic          in_v,
    input  logic          in_c,
    input  logic [3:0]    in_cond,
    input  logic          in_setflags,
    input  logic [RA-1:0] in_rd,
    input  logic          in_regwrite,
    input  logic          in_memwrite,
    input  logic          in_branch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_result,
    output logic [RA-1:0] out_rd,
    output logic          out_regwrite,
    output logic          out_memwrite,
    output logic          out_branch,
    output logic          out_condpass,
    output logic [3:0]    flags_nzcv
);

    typedef enum logic [3:0] {
        C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
        C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
        C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
        C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
    } cond_e;

    cond_e       cond;
    logic        fn, fz, fc, fv;
    logic        pass;
    logic        push, pop;
    logic [1:0]  count, count_nx;
    logic        wptr, rptr;

    logic [M-1:0]  res_q [2];
    logic [RA-1:0] rd_q  [2];
    logic [3:0]    ctl_q [2];   // {regwrite, memwrite, branch, condpass}

    assign {fn, fz, fc, fv} = flags_nzcv;

    always_comb begin
        cond = cond_e'(in_cond);
        pass = 1'b0;
        case (cond)
            C_EQ:    pass = fz;
            C_NE:    pass = !fz;
            C_CS:    pass = fc;
            C_CC:    pass = !fc;
            C_MI:    pass = fn;
            C_PL:    pass = !fn;
            C_VS:    pass = fv;
            C_VC:    pass = !fv;
            C_HI:    pass = fc & !fz;
            C_LS:    pass = !fc | fz;
            C_GE:    pass = (fn == fv);
            C_LT:    pass = (fn != fv);
            C_GT:    pass = !fz & (fn == fv);
            C_LE:    pass = fz | (fn != fv);
            C_AL:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_nx = count + {1'b0, push} - {1'b0, pop};
    end

    // in_ready is registered from the next count so it never depends on in_valid/out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            in_ready   <= 1'b0;
            flags_nzcv <= '0;
            res_q[0]   <= '0;
            res_q[1]   <= '0;
            rd_q[0]    <= '0;
            rd_q[1]    <= '0;
            ctl_q[0]   <= '0;
            ctl_q[1]   <= '0;
        end else begin
            count    <= count_nx;
            in_ready <= (count_nx < 2'd2);
            if (push) begin
                res_q[wptr] <= in_result;
                rd_q[wptr]  <= in_rd;
                ctl_q[wptr] <= {in_regwrite & pass, in_memwrite & pass, in_branch & pass, pass};
                wptr        <= ~wptr;
                if (pass & in_setflags)
                    flags_nzcv <= {in_n, in_z, in_c, in_v};
            end
            if (pop)
                rptr <= ~rptr;
        end
    end

    assign out_result   = res_q[rptr];
    assign out_rd       = rd_q[rptr];
    assign out_regwrite = ctl_q[rptr][3];
    assign out_memwrite = ctl_q[rptr][2];
    assign out_branch   = ctl_q[rptr][1];
    assign out_condpass = ctl_q[rptr][0];

endmodule

// File: tb/tb_alu_cond_writeback.sv
// Scoreboard bench for alu_cond_writeback: directed scenarios, a full cond x NZCV sweep, random traffic.
module tb_alu_cond_writeback;

    localparam int M  = 32;
    localparam int RA = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [M-1:0]  in_result;
    logic          in_n, in_z, in_v, in_c;
    logic [3:0]    in_cond;
    logic          in_setflags;
    logic [RA-1:0] in_rd;
    logic          in_regwrite, in_memwrite, in_branch;
    logic          out_valid, out_ready;
    logic [M-1:0]  out_result;
    logic [RA-1:0] out_rd;
    logic          out_regwrite, out_memwrite, out_branch, out_condpass;
    logic [3:0]    flags_nzcv;

    alu_cond_writeback #(.M(M), .RA(RA)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_n(in_n), .in_z(in_z), .in_v(in_v), .in_c(in_c),
        .in_cond(in_cond), .in_setflags(in_setflags), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_memwrite(in_memwrite), .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
        .out_branch(out_branch), .out_condpass(out_condpass),
        .flags_nzcv(flags_nzcv)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          started = 1'b0;
    logic [3:0]  mflags = 4'b0000;
    logic [63:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference condition check: base test from cond[3:1], inverted by cond[0]
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cf;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cf && !z;
            3'd5:    b = (n == v);
            3'd6:    b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    // Stimulus side of the scoreboard: predict each accepted instruction
    always @(negedge clk) begin
        if (started && rst_n) begin
            chk("flags", {60'd0, flags_nzcv}, {60'd0, mflags});
            if (in_valid && in_ready) begin
                bit p;
                p = cond_ok(in_cond, mflags);
                sb.push_back({24'd0, in_result, in_rd, in_regwrite & p, in_memwrite & p, in_branch & p, p});
                if (p && in_setflags)
                    mflags = {in_n, in_z, in_c, in_v};
            end
        end
    end

    // Monitor: pop and compare on every output transfer
    always @(negedge clk) begin
        if (started && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_output: got out_valid=1 expected no pending entry at %0t", $time);
            end else begin
                chk("entry", {24'd0, out_result, out_rd, out_regwrite, out_memwrite, out_branch, out_condpass},
                    sb.pop_front());
            end
        end
    end

    // Handshake/reset state check just after each edge
    always @(posedge clk) begin
        bit lr;
        lr = rst_n;
        if (!lr) begin
            sb.delete();
            mflags = 4'b0000;
            started = 1'b1;
        end
        #1;
        if (started) begin
            chk("in_ready",  {63'd0, in_ready},  {63'd0, lr && (sb.size() < 2)});
            chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
            if (!lr)
                chk("reset_out", {24'd0, out_result, out_rd, out_regwrite, out_memwrite, out_branch, out_condpass, flags_nzcv},
                    64'd0);
        end
    end

    task automatic send(input logic [3:0] c, input logic s, input logic [3:0] f, input logic [RA-1:0] rd,
                        input logic [M-1:0] r, input logic rw, input logic mw, input logic br);
        int n = 0;
        in_cond = c; in_setflags = s; {in_n, in_z, in_c, in_v} = f;
        in_rd = rd; in_result = r; in_regwrite = rw; in_memwrite = mw; in_branch = br;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 expected accept within 50 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_result = '0; in_rd = '0; in_cond = '0; in_setflags = 1'b0;
        {in_n, in_z, in_c, in_v} = 4'b0000;
        {in_regwrite, in_memwrite, in_branch} = 3'b000;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // AL with S sets Z; dependent EQ/NE issue back-to-back
        send(4'b1110, 1'b1, 4'b0100, 4'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("al_flags", {60'd0, flags_nzcv}, 64'h4);
        chk("al_regwrite", {63'd0, out_regwrite}, 64'd1);
        send(4'b0000, 1'b0, 4'b0000, 4'd2, 32'h1234, 1'b1, 1'b0, 1'b0);
        chk("eq_pass", {63'd0, out_condpass}, 64'd1);
        send(4'b0001, 1'b0, 4'b0000, 4'd3, 32'h5678, 1'b1, 1'b1, 1'b1);
        chk("ne_pass", {63'd0, out_condpass}, 64'd0);
        chk("ne_enables", {61'd0, out_regwrite, out_memwrite, out_branch}, 64'd0);
        send(4'b0001, 1'b1, 4'b1000, 4'd4, 32'h9abc, 1'b0, 1'b1, 1'b0);
        chk("fail_memwrite", {63'd0, out_memwrite}, 64'd0);
        chk("fail_flags_kept", {60'd0, flags_nzcv}, 64'h4);
        idle(3);

        // Fill with out_ready low; third instruction (with S) must wait and not touch flags
        out_ready = 1'b0;
        send(4'b1110, 1'b0, 4'b0000, 4'd5, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        send(4'b1110, 1'b0, 4'b0000, 4'd6, 32'hA5A5_0002, 1'b0, 1'b1, 1'b0);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        fork
            begin
                idle(4);
                chk("held_flags", {60'd0, flags_nzcv}, 64'h4);
                out_ready = 1'b1;
            end
            send(4'b1110, 1'b1, 4'b1011, 4'd7, 32'hA5A5_0003, 1'b0, 1'b0, 1'b1);
        join
        idle(4);

        // Steady state at count=1: push and pop every cycle
        out_ready = 1'b0;
        send(4'b1110, 1'b0, 4'b0000, 4'd8, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send(4'b1110, 1'b0, 4'b0000, 4'(i), 32'(i + 'h200), 1'b1, 1'b0, 1'b0);
        idle(3);

        // Reset with two entries buffered and flags 1111
        send(4'b1110, 1'b1, 4'b1111, 4'd9, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        out_ready = 1'b0;
        send(4'b1110, 1'b0, 4'b0000, 4'd10, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_flags", {60'd0, flags_nzcv}, 64'hF);
        rst_n = 1'b0;
        idle(1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags", {60'd0, flags_nzcv}, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Sweep every condition code against every NZCV value
        for (int f = 0; f < 16; f++) begin
            send(4'b1110, 1'b1, 4'(f), 4'd0, 32'(f), 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++)
                send(4'(c), 1'b0, 4'b0000, 4'(c), $urandom, 1'b1, 1'b1, 1'b1);
        end
        idle(3);

        // Random traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_result = $urandom;
            in_rd = 4'($urandom);
            in_cond = 4'($urandom);
            in_setflags = 1'($urandom);
            {in_n, in_z, in_c, in_v} = 4'($urandom);
            {in_regwrite, in_memwrite, in_branch} = 3'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
